// File: rtl/cim_host_if.sv
// Host-side command/readback bundle for the CIM command dispatcher.
// The host drives commands in; the dispatcher returns ready and load data.
interface cim_host_if #(
    parameter int ROW_W = 64
);
    logic             host_valid;
    logic             host_ready;
    logic [31:0]      host_cmd;
    logic [ROW_W-1:0] host_wdata;
    logic             rdata_valid;
    logic [ROW_W-1:0] rdata;

    modport master (
        output host_valid, host_cmd, host_wdata,
        input  host_ready, rdata_valid, rdata
    );

    modport slave (
        input  host_valid, host_cmd, host_wdata,
        output host_ready, rdata_valid, rdata
    );
endinterface

// File: rtl/cim_cmd_dispatcher.sv
// In-order command dispatcher: host FIFO feeding one issue slot that drives
// either a single-cycle load/store or a held compute request to the MUL controller.
module cim_cmd_dispatcher #(
    parameter int DEPTH = 4,
    parameter int ROW_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    cim_host_if.slave         host,
    output logic              ExLdSt_valid,
    output logic [6:0]        ExLdSt_command,
    inout  wire  [ROW_W-1:0]  ExLdSt_data,
    output logic              Compute_valid,
    input  logic              Compute_ready,
    output logic [24:0]       Compute_command,
    output logic              idle,
    output logic              err_illegal
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic             kind;
        logic [24:0]      cmd;
        logic [ROW_W-1:0] wdata;
    } entry_t;

    typedef enum logic [1:0] {S_EMPTY, S_LDST, S_COMP} slot_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    slot_t            slot_q, slot_d;
    logic [24:0]      slot_cmd_q, slot_cmd_d;
    logic [ROW_W-1:0] slot_wdata_q, slot_wdata_d;
    logic [ROW_W-1:0] rdata_q, rdata_d;
    logic             rdata_valid_q, rdata_valid_d;
    logic             err_q, err_d;

    logic   full, empty, push, pop, retire, is_load;
    entry_t head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            slot_q        <= S_EMPTY;
            slot_cmd_q    <= '0;
            slot_wdata_q  <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            slot_q        <= slot_d;
            slot_cmd_q    <= slot_cmd_d;
            slot_wdata_q  <= slot_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        full    = (count_q == CNT_FULL);
        empty   = (count_q == '0);
        // Full blocks the host even if the head pops this cycle.
        push    = host.host_valid & ~full;
        retire  = (slot_q == S_EMPTY) | (slot_q == S_LDST) |
                  ((slot_q == S_COMP) & Compute_ready);
        pop     = ~empty & retire;
        head    = mem_q[rd_ptr_q];
        is_load = (slot_q == S_LDST) & ~slot_cmd_q[6];

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{kind: host.host_cmd[31], cmd: host.host_cmd[24:0],
                                wdata: host.host_wdata};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push & ~pop) count_d = count_q + 1'b1;
        else if (pop & ~push) count_d = count_q - 1'b1;

        slot_d       = slot_q;
        slot_cmd_d   = slot_cmd_q;
        slot_wdata_d = slot_wdata_q;
        err_d        = 1'b0;
        if (retire) slot_d = S_EMPTY;
        if (pop) begin
            if (head.kind) begin
                slot_d       = S_LDST;
                slot_cmd_d   = {18'b0, head.cmd[6:0]};
                slot_wdata_d = head.wdata;
            end else if (head.cmd[23:21] == 3'b000) begin
                // Mode 000 is not a valid MUL operation: drop it and flag.
                err_d = 1'b1;
            end else begin
                slot_d     = S_COMP;
                slot_cmd_d = head.cmd;
            end
        end

        rdata_d       = is_load ? ExLdSt_data : rdata_q;
        rdata_valid_d = is_load;
    end

    assign host.host_ready  = ~full;
    assign host.rdata_valid = rdata_valid_q;
    assign host.rdata       = rdata_q;
    assign ExLdSt_valid     = (slot_q == S_LDST);
    assign ExLdSt_command   = slot_cmd_q[6:0];
    assign ExLdSt_data      = ((slot_q == S_LDST) && slot_cmd_q[6]) ? slot_wdata_q : 'z;
    assign Compute_valid    = (slot_q == S_COMP);
    assign Compute_command  = slot_cmd_q;
    assign idle             = empty & (slot_q == S_EMPTY);
    assign err_illegal      = err_q;
endmodule

// File: tb/tb_cim_cmd_dispatcher.sv
// Directed and randomized checks of cim_cmd_dispatcher against an in-order
// command queue model of what the MUL controller should observe.
module tb_cim_cmd_dispatcher;
    localparam int DEPTH = 4;
    localparam int ROW_W = 64;

    typedef struct packed {
        logic             kind;
        logic [24:0]      cmd;
        logic [ROW_W-1:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cim_host_if #(.ROW_W(ROW_W)) hif();
    wire  [ROW_W-1:0] ExLdSt_data;
    logic             ExLdSt_valid;
    logic [6:0]       ExLdSt_command;
    logic             Compute_valid;
    logic             Compute_ready;
    logic [24:0]      Compute_command;
    logic             idle;
    logic             err_illegal;
    logic [ROW_W-1:0] load_val;

    // The MUL controller returns load data while a load is on the bus.
    assign ExLdSt_data = (ExLdSt_valid && !ExLdSt_command[6]) ? load_val : 'z;

    cim_cmd_dispatcher #(.DEPTH(DEPTH), .ROW_W(ROW_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .host            (hif),
        .ExLdSt_valid    (ExLdSt_valid),
        .ExLdSt_command  (ExLdSt_command),
        .ExLdSt_data     (ExLdSt_data),
        .Compute_valid   (Compute_valid),
        .Compute_ready   (Compute_ready),
        .Compute_command (Compute_command),
        .idle            (idle),
        .err_illegal     (err_illegal)
    );

    int               vectors = 0;
    int               miscompares = 0;
    exp_t             exp_q[$];
    int               exp_err = 0;
    int               err_seen = 0;
    logic             pend_rd = 1'b0;
    logic [ROW_W-1:0] pend_val = '0;
    logic             hold_pend = 1'b0;
    logic [24:0]      hold_cmd = '0;
    logic             ld_rand = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        pend_rd   = 1'b0;
        hold_pend = 1'b0;
    endtask

    // One clock: check what the controller sees before the edge, update the model, advance.
    task automatic tick();
        exp_t e;
        if (ld_rand) load_val = {$urandom, $urandom};
        #1;
        if (hold_pend) begin
            chk("comp_hold_valid", 64'(Compute_valid), 64'd1);
            chk("comp_hold_cmd", 64'(Compute_command), 64'(hold_cmd));
        end
        chk("rdata_valid", 64'(hif.rdata_valid), 64'(pend_rd));
        if (pend_rd) chk("rdata", hif.rdata, pend_val);
        if (err_illegal) err_seen++;
        if (ExLdSt_valid) begin
            chk("ldst_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ldst_kind", 64'(e.kind), 64'd1);
                chk("ldst_cmd", 64'(ExLdSt_command), 64'(e.cmd[6:0]));
                if (e.cmd[6]) chk("store_data", ExLdSt_data, e.wdata);
            end
        end
        pend_rd  = ExLdSt_valid && !ExLdSt_command[6];
        pend_val = load_val;
        if (Compute_valid && Compute_ready) begin
            chk("comp_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("comp_kind", 64'(e.kind), 64'd0);
                chk("comp_cmd", 64'(Compute_command), 64'(e.cmd));
            end
        end
        hold_pend = Compute_valid && !Compute_ready;
        hold_cmd  = Compute_command;
        if (hif.host_valid && hif.host_ready) begin
            if (!hif.host_cmd[31] && hif.host_cmd[23:21] == 3'b000) exp_err++;
            else exp_q.push_back('{kind: hif.host_cmd[31], cmd: hif.host_cmd[24:0],
                                   wdata: hif.host_wdata});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] cmd, input logic [ROW_W-1:0] wdata);
        logic accepted;
        accepted        = 1'b0;
        hif.host_valid  = 1'b1;
        hif.host_cmd    = cmd;
        hif.host_wdata  = wdata;
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = hif.host_ready;
            tick();
        end
        hif.host_valid = 1'b0;
        chk("push_accepted", 64'(accepted), 64'd1);
    endtask

    function automatic logic [31:0] comp(input logic [2:0] mode, input logic [2:0] len,
                                         input logic [5:0] rs1, input logic [5:0] rs2,
                                         input logic [5:0] rd);
        return {7'b0, 1'b0, mode, len, rs1, rs2, rd};
    endfunction

    initial begin
        logic [31:0] cmul;
        logic [31:0] cf [DEPTH+1];
        int          e0, cv;
        logic        kind;
        logic [31:0] rc;

        hif.host_valid = 1'b0;
        hif.host_cmd   = '0;
        hif.host_wdata = '0;
        Compute_ready  = 1'b0;
        load_val       = '0;

        // Reset state
        #3;
        chk("rst_host_ready", 64'(hif.host_ready), 64'd1);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_ldst_valid", 64'(ExLdSt_valid), 64'd0);
        chk("rst_comp_valid", 64'(Compute_valid), 64'd0);
        chk("rst_rdata_valid", 64'(hif.rdata_valid), 64'd0);
        chk("rst_rdata", hif.rdata, 64'd0);
        chk("rst_err", 64'(err_illegal), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Store issue and data drive
        push(32'h8000_0045, {8{8'h5A}});
        chk("st_not_yet", 64'(ExLdSt_valid), 64'd0);
        tick();
        chk("st_valid", 64'(ExLdSt_valid), 64'd1);
        chk("st_cmd", 64'(ExLdSt_command), 64'h45);
        chk("st_data", ExLdSt_data, {8{8'h5A}});
        tick();
        chk("st_done", 64'(ExLdSt_valid), 64'd0);
        chk("st_idle", 64'(idle), 64'd1);

        // Load capture
        load_val = {8{8'hA5}};
        push(32'h8000_0003, '0);
        tick();
        chk("ld_valid", 64'(ExLdSt_valid), 64'd1);
        chk("ld_cmd", 64'(ExLdSt_command), 64'h03);
        tick();
        chk("ld_rvalid", 64'(hif.rdata_valid), 64'd1);
        chk("ld_rdata", hif.rdata, {8{8'hA5}});
        tick();
        chk("ld_rvalid_pulse", 64'(hif.rdata_valid), 64'd0);
        chk("ld_rdata_hold", hif.rdata, {8{8'hA5}});

        // Compute held by the controller, then a queued store
        cmul = comp(3'b111, 3'b010, 6'd1, 6'd2, 6'd3);
        push(cmul, '0);
        push(32'h8000_0047, {8{8'h3C}});
        for (int i = 0; i < 3; i++) begin
            chk("mul_valid", 64'(Compute_valid), 64'd1);
            chk("mul_cmd", 64'(Compute_command), 64'(cmul[24:0]));
            chk("mul_st_wait", 64'(ExLdSt_valid), 64'd0);
            tick();
        end
        Compute_ready = 1'b1;
        tick();
        chk("mul_released", 64'(Compute_valid), 64'd0);
        chk("mul_st_issue", 64'(ExLdSt_valid), 64'd1);
        chk("mul_st_cmd", 64'(ExLdSt_command), 64'h47);
        tick();

        // Fill the FIFO behind a stalled compute
        Compute_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            cf[i] = comp(3'b001, 3'(i), 6'(i), 6'(i + 1), 6'(i + 2));
            push(cf[i], '0);
        end
        chk("full_ready", 64'(hif.host_ready), 64'd0);
        chk("full_idle", 64'(idle), 64'd0);
        chk("full_head", 64'(Compute_command), 64'(cf[0][24:0]));
        hif.host_valid = 1'b1;
        hif.host_cmd   = comp(3'b010, 3'd7, 6'd9, 6'd9, 6'd9);
        tick();
        chk("full_blocked", 64'(hif.host_ready), 64'd0);
        Compute_ready = 1'b1;
        tick();
        hif.host_valid = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            chk("drain_valid", 64'(Compute_valid), 64'd1);
            chk("drain_cmd", 64'(Compute_command), 64'(cf[i][24:0]));
            tick();
        end
        chk("drain_done", 64'(Compute_valid), 64'd0);
        chk("drain_idle", 64'(idle), 64'd1);

        // Illegal compute between two stores
        e0 = err_seen;
        cv = 0;
        push(32'h8000_0041, {4{16'h1234}});
        push(comp(3'b000, 3'd1, 6'd4, 6'd5, 6'd6), '0);
        push(32'h8000_0042, {4{16'hBEEF}});
        for (int i = 0; i < 5; i++) begin
            if (Compute_valid) cv++;
            tick();
        end
        chk("ill_err_pulses", 64'(err_seen - e0), 64'd1);
        chk("ill_no_compute", 64'(cv), 64'd0);
        chk("ill_idle", 64'(idle), 64'd1);

        // Asynchronous reset while a compute is pending
        Compute_ready = 1'b0;
        push(cmul, '0);
        tick();
        chk("rstc_valid", 64'(Compute_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstc_async_drop", 64'(Compute_valid), 64'd0);
        chk("rstc_idle", 64'(idle), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();
        Compute_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rstc_no_reissue", 64'(Compute_valid), 64'd0);
            tick();
        end
        chk("rstc_idle_after", 64'(idle), 64'd1);

        // Randomized traffic against the queue model
        ld_rand = 1'b1;
        for (int n = 0; n < 400; n++) begin
            kind = 1'($urandom_range(0, 1));
            rc   = $urandom;
            rc[31] = kind;
            if (!kind && $urandom_range(0, 7) == 0) rc[23:21] = 3'b000;
            hif.host_valid = ($urandom_range(0, 3) != 0);
            hif.host_cmd   = rc;
            hif.host_wdata = {$urandom, $urandom};
            Compute_ready  = 1'($urandom_range(0, 1));
            tick();
        end
        hif.host_valid = 1'b0;
        Compute_ready  = 1'b1;
        for (int i = 0; i < 40 && !idle; i++) tick();
        tick();
        tick();
        chk("rand_idle", 64'(idle), 64'd1);
        chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("rand_err_count", 64'(err_seen), 64'(exp_err));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
